// File: rtl/branch_redirect_ctrl_pkg.sv
// rtl/branch_redirect_ctrl_pkg.sv - shared constants for the branch redirect controller
// Holds the FSM state encoding, the default sequential PC increment and
// the helper that word-aligns a fetch address.
package branch_redirect_ctrl_pkg;

    localparam logic [2:0] L_PARAM_BRC_IDLE     = 3'd0;
    localparam logic [2:0] L_PARAM_BRC_FLUSH    = 3'd1;
    localparam logic [2:0] L_PARAM_BRC_REDIRECT = 3'd2;
    localparam logic [2:0] L_PARAM_BRC_IBWAIT   = 3'd3;
    localparam logic [2:0] L_PARAM_BRC_HALT     = 3'd4;

    localparam int unsigned P_PC_INC_DEFAULT = 4;

    // Fetch only ever sees word-aligned addresses.
    function automatic logic [31:0] brc_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/branch_redirect_stat.sv
// rtl/branch_redirect_stat.sv - saturating branch / mispredict counter pair
// Ports: clk, rst_n (async active-low), sync_clr (synchronous clear),
//        branch_inc / miss_inc (one-cycle increment strobes),
//        branch_cnt / miss_cnt (counter values, saturate at all-ones).
module branch_redirect_stat #(
    parameter int unsigned P_STAT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sync_clr,
    input  logic                branch_inc,
    input  logic                miss_inc,
    output logic [P_STAT_W-1:0] branch_cnt,
    output logic [P_STAT_W-1:0] miss_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt <= '0;
            miss_cnt   <= '0;
        end else if (sync_clr) begin
            branch_cnt <= '0;
            miss_cnt   <= '0;
        end else begin
            if (branch_inc && (branch_cnt != '1)) branch_cnt <= branch_cnt + 1'b1;
            if (miss_inc && (miss_cnt != '1))     miss_cnt   <= miss_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - fetch-side branch resolution / redirect / halt controller
// Ports: iCLOCK, inRESET (async active-low), iRESET_SYNC (sync clear);
//        execute event: iEXE_VALID, oEXE_BUSY, iPC, iBRANCH_ADDR, class bits,
//        iPRED_TAKEN, iPRED_ADDR; oFLUSH pulse; redirect handshake
//        oREDIRECT_VALID/oREDIRECT_ADDR/iREDIRECT_READY; interrupt-branch
//        handshake oIB_REQ/iIB_ACK; oHALT with iWAKEUP.
// Optional: MIST32_BRANCH_STAT_EN adds oSTAT_BRANCH / oSTAT_MISS counters.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int unsigned P_PC_INC = P_PC_INC_DEFAULT,
    parameter int unsigned P_STAT_W = 32
) (
    input  logic                iCLOCK,
    input  logic                inRESET,
    input  logic                iRESET_SYNC,
    input  logic                iEXE_VALID,
    output logic                oEXE_BUSY,
    input  logic [31:0]         iPC,
    input  logic [31:0]         iBRANCH_ADDR,
    input  logic                iJUMP_VALID,
    input  logic                iNOT_JUMP_VALID,
    input  logic                iIB_VALID,
    input  logic                iIDTS_VALID,
    input  logic                iHALT_VALID,
    input  logic                iPRED_TAKEN,
    input  logic [31:0]         iPRED_ADDR,
    output logic                oFLUSH,
    output logic                oREDIRECT_VALID,
    output logic [31:0]         oREDIRECT_ADDR,
    input  logic                iREDIRECT_READY,
    output logic                oIB_REQ,
    input  logic                iIB_ACK,
    output logic                oHALT,
`ifdef MIST32_BRANCH_STAT_EN
    output logic [P_STAT_W-1:0] oSTAT_BRANCH,
    output logic [P_STAT_W-1:0] oSTAT_MISS,
`endif
    input  logic                iWAKEUP
);

    logic [2:0]  state;
    logic [2:0]  after_flush;   // where FLUSH goes next, chosen at accept time
    logic [31:0] addr_q;

    logic        accept;
    logic        take;
    logic [2:0]  nxt_after;
    logic [31:0] nxt_addr;
    logic        branch_inc;
    logic        miss_inc;
    logic [31:0] seq_pc;

    assign accept = iEXE_VALID && (state == L_PARAM_BRC_IDLE);
    assign seq_pc = iPC + 32'(P_PC_INC);

    // Resolve the winning class; HALT > IB > IDTS > JUMP > NOT_JUMP.
    always_comb begin
        take       = 1'b0;
        nxt_after  = L_PARAM_BRC_REDIRECT;
        nxt_addr   = addr_q;
        branch_inc = 1'b0;
        miss_inc   = 1'b0;
        if (iHALT_VALID) begin
            take      = 1'b1;
            nxt_after = L_PARAM_BRC_HALT;
            nxt_addr  = brc_align(seq_pc);
        end else if (iIB_VALID) begin
            take      = 1'b1;
            nxt_after = L_PARAM_BRC_IBWAIT;
        end else if (iIDTS_VALID) begin
            take      = 1'b1;
            nxt_addr  = brc_align(seq_pc);
        end else if (iJUMP_VALID) begin
            branch_inc = 1'b1;
            if (!iPRED_TAKEN || (iPRED_ADDR != iBRANCH_ADDR)) begin
                take     = 1'b1;
                miss_inc = 1'b1;
                nxt_addr = brc_align(iBRANCH_ADDR);
            end
        end else if (iNOT_JUMP_VALID) begin
            branch_inc = 1'b1;
            if (iPRED_TAKEN) begin
                take     = 1'b1;
                miss_inc = 1'b1;
                nxt_addr = brc_align(seq_pc);
            end
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state       <= L_PARAM_BRC_IDLE;
            after_flush <= L_PARAM_BRC_IDLE;
            addr_q      <= '0;
        end else if (iRESET_SYNC) begin
            state       <= L_PARAM_BRC_IDLE;
            after_flush <= L_PARAM_BRC_IDLE;
            addr_q      <= '0;
        end else begin
            case (state)
                L_PARAM_BRC_IDLE: begin
                    if (accept && take) begin
                        state       <= L_PARAM_BRC_FLUSH;
                        after_flush <= nxt_after;
                        addr_q      <= nxt_addr;
                    end
                end
                L_PARAM_BRC_FLUSH:    state <= after_flush;
                L_PARAM_BRC_REDIRECT: if (iREDIRECT_READY) state <= L_PARAM_BRC_IDLE;
                L_PARAM_BRC_IBWAIT:   if (iIB_ACK)         state <= L_PARAM_BRC_IDLE;
                L_PARAM_BRC_HALT:     if (iWAKEUP)         state <= L_PARAM_BRC_REDIRECT;
                default:              state <= L_PARAM_BRC_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so an async reset clears them at once.
    assign oEXE_BUSY       = (state != L_PARAM_BRC_IDLE);
    assign oFLUSH          = (state == L_PARAM_BRC_FLUSH);
    assign oREDIRECT_VALID = (state == L_PARAM_BRC_REDIRECT);
    assign oIB_REQ         = (state == L_PARAM_BRC_IBWAIT);
    assign oHALT           = (state == L_PARAM_BRC_HALT);
    assign oREDIRECT_ADDR  = addr_q;

`ifdef MIST32_BRANCH_STAT_EN
    branch_redirect_stat #(
        .P_STAT_W (P_STAT_W)
    ) u_stat (
        .clk        (iCLOCK),
        .rst_n      (inRESET),
        .sync_clr   (iRESET_SYNC),
        .branch_inc (accept && branch_inc),
        .miss_inc   (accept && miss_inc),
        .branch_cnt (oSTAT_BRANCH),
        .miss_cnt   (oSTAT_MISS)
    );
`else
    localparam int unsigned L_UNUSED_STAT_W = P_STAT_W;
    logic unused_stat;
    assign unused_stat = branch_inc ^ miss_inc;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - self-checking bench for branch_redirect_ctrl
module tb_branch_redirect_ctrl;

    logic        iCLOCK = 1'b0;
    logic        inRESET, iRESET_SYNC, iEXE_VALID, oEXE_BUSY;
    logic [31:0] iPC, iBRANCH_ADDR, iPRED_ADDR, oREDIRECT_ADDR;
    logic        iJUMP_VALID, iNOT_JUMP_VALID, iIB_VALID, iIDTS_VALID, iHALT_VALID;
    logic        iPRED_TAKEN, oFLUSH, oREDIRECT_VALID, iREDIRECT_READY;
    logic        oIB_REQ, iIB_ACK, oHALT, iWAKEUP;
`ifdef MIST32_BRANCH_STAT_EN
    logic [31:0] oSTAT_BRANCH, oSTAT_MISS;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_branch = 0;
    int exp_miss   = 0;

    branch_redirect_ctrl dut (
        .iCLOCK          (iCLOCK),
        .inRESET         (inRESET),
        .iRESET_SYNC     (iRESET_SYNC),
        .iEXE_VALID      (iEXE_VALID),
        .oEXE_BUSY       (oEXE_BUSY),
        .iPC             (iPC),
        .iBRANCH_ADDR    (iBRANCH_ADDR),
        .iJUMP_VALID     (iJUMP_VALID),
        .iNOT_JUMP_VALID (iNOT_JUMP_VALID),
        .iIB_VALID       (iIB_VALID),
        .iIDTS_VALID     (iIDTS_VALID),
        .iHALT_VALID     (iHALT_VALID),
        .iPRED_TAKEN     (iPRED_TAKEN),
        .iPRED_ADDR      (iPRED_ADDR),
        .oFLUSH          (oFLUSH),
        .oREDIRECT_VALID (oREDIRECT_VALID),
        .oREDIRECT_ADDR  (oREDIRECT_ADDR),
        .iREDIRECT_READY (iREDIRECT_READY),
        .oIB_REQ         (oIB_REQ),
        .iIB_ACK         (iIB_ACK),
        .oHALT           (oHALT),
`ifdef MIST32_BRANCH_STAT_EN
        .oSTAT_BRANCH    (oSTAT_BRANCH),
        .oSTAT_MISS      (oSTAT_MISS),
`endif
        .iWAKEUP         (iWAKEUP)
    );

    always #5 iCLOCK = ~iCLOCK;

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_event();
        iEXE_VALID = 0; iJUMP_VALID = 0; iNOT_JUMP_VALID = 0; iIB_VALID = 0;
        iIDTS_VALID = 0; iHALT_VALID = 0; iPRED_TAKEN = 0;
    endtask

    // Reference: act 0 = nothing, 1 = flush+redirect, 2 = flush+IB, 3 = flush+halt.
    task automatic ref_model(input bit j, nj, ib, idts, hlt, pt,
                             input logic [31:0] pc, ba, pa,
                             output int act, output logic [31:0] tgt,
                             output bit br, output bit miss);
        logic [31:0] seq;
        seq  = pc + 32'd4;
        act  = 0; tgt = 32'd0; br = 0; miss = 0;
        if (hlt)        begin act = 3; tgt = seq; end
        else if (ib)    act = 2;
        else if (idts)  begin act = 1; tgt = seq; end
        else if (j) begin
            br = 1;
            if (!(pt && pa == ba)) begin act = 1; tgt = ba; miss = 1; end
        end else if (nj) begin
            br = 1;
            if (pt) begin act = 1; tgt = seq; miss = 1; end
        end
        tgt = tgt & 32'hFFFF_FFFC;
    endtask

    // Redirect phase: stall cycles with ready low (and ignored busy-time noise),
    // then ready. stall==0 means ready was already raised before valid.
    task automatic do_redirect(input logic [31:0] tgt, input int stall);
        for (int k = 0; k < stall; k++) begin
            chk("redir_valid_stall", oREDIRECT_VALID, 1);
            chk("redir_addr_stall", oREDIRECT_ADDR, tgt);
            iEXE_VALID  = $urandom_range(0, 1);
            iJUMP_VALID = 1; iHALT_VALID = $urandom_range(0, 1);
            iWAKEUP     = $urandom_range(0, 1);
            iIB_ACK     = $urandom_range(0, 1);
            iPC         = $urandom;
            tick();
            clear_event(); iWAKEUP = 0; iIB_ACK = 0;
        end
        iREDIRECT_READY = 1;
        chk("redir_valid", oREDIRECT_VALID, 1);
        chk("redir_addr", oREDIRECT_ADDR, tgt);
        chk("redir_no_halt", oHALT, 0);
        tick();
        iREDIRECT_READY = 0;
        chk("redir_done_valid", oREDIRECT_VALID, 0);
        chk("redir_done_busy", oEXE_BUSY, 0);
    endtask

    task automatic run_event(input bit j, nj, ib, idts, hlt, pt,
                             input logic [31:0] pc, ba, pa,
                             input int stall, input int hold);
        int act; logic [31:0] tgt; bit br, miss;
        ref_model(j, nj, ib, idts, hlt, pt, pc, ba, pa, act, tgt, br, miss);
        exp_branch += int'(br);
        exp_miss   += int'(miss);
        iJUMP_VALID = j; iNOT_JUMP_VALID = nj; iIB_VALID = ib; iIDTS_VALID = idts;
        iHALT_VALID = hlt; iPRED_TAKEN = pt; iPC = pc; iBRANCH_ADDR = ba; iPRED_ADDR = pa;
        iEXE_VALID = 1;
        chk("busy_before", oEXE_BUSY, 0);
        tick();
        clear_event();
        chk("flush_n1", oFLUSH, (act != 0));
        chk("busy_n1", oEXE_BUSY, (act != 0));
        chk("valid_n1", oREDIRECT_VALID, 0);
        if (act == 0) return;
        if (stall == 0 && act == 1) iREDIRECT_READY = 1;
        tick();
        chk("flush_n2", oFLUSH, 0);
        if (act == 1) begin
            do_redirect(tgt, stall);
        end else if (act == 2) begin
            for (int k = 0; k < stall; k++) begin
                chk("ib_req_wait", oIB_REQ, 1);
                chk("ib_no_redirect", oREDIRECT_VALID, 0);
                tick();
            end
            iIB_ACK = 1;
            chk("ib_req_ack", oIB_REQ, 1);
            tick();
            iIB_ACK = 0;
            chk("ib_req_done", oIB_REQ, 0);
            chk("ib_no_redirect_after", oREDIRECT_VALID, 0);
            chk("ib_busy_done", oEXE_BUSY, 0);
        end else begin
            for (int k = 0; k < hold; k++) begin
                chk("halt_held", oHALT, 1);
                chk("halt_no_redirect", oREDIRECT_VALID, 0);
                iREDIRECT_READY = $urandom_range(0, 1);
                iIB_ACK = $urandom_range(0, 1);
                tick();
                iREDIRECT_READY = 0; iIB_ACK = 0;
            end
            iWAKEUP = 1;
            if (stall == 0) iREDIRECT_READY = 1;
            chk("halt_before_wake", oHALT, 1);
            tick();
            iWAKEUP = 0;
            chk("halt_after_wake", oHALT, 0);
            do_redirect(tgt, stall);
        end
    endtask

    task automatic chk_stats();
`ifdef MIST32_BRANCH_STAT_EN
        chk("stat_branch", oSTAT_BRANCH, 32'(exp_branch));
        chk("stat_miss", oSTAT_MISS, 32'(exp_miss));
`endif
    endtask

    initial begin
        inRESET = 0; iRESET_SYNC = 0; iREDIRECT_READY = 0; iIB_ACK = 0; iWAKEUP = 0;
        iPC = 0; iBRANCH_ADDR = 0; iPRED_ADDR = 0;
        clear_event();
        #2;
        chk("rst_busy", oEXE_BUSY, 0);
        chk("rst_flush", oFLUSH, 0);
        chk("rst_valid", oREDIRECT_VALID, 0);
        chk("rst_addr", oREDIRECT_ADDR, 0);
        chk("rst_ib", oIB_REQ, 0);
        chk("rst_halt", oHALT, 0);
        tick(); tick();
        inRESET = 1;
        tick();

        // Correct taken prediction: zero latency, nothing happens.
        run_event(1, 0, 0, 0, 0, 1, 32'h0000_0F00, 32'h0000_1000, 32'h0000_1000, 0, 0);
        // Not-taken mispredict with 3-cycle fetch stall.
        run_event(0, 1, 0, 0, 0, 1, 32'h0000_2000, 32'h0000_3000, 32'h0000_3000, 3, 0);
        // IDTS wrap-around.
        run_event(0, 0, 0, 1, 0, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1, 0);
        // Halt for 10 cycles then wake.
        run_event(0, 0, 0, 0, 1, 0, 32'h0000_0100, 32'h0, 32'h0, 2, 10);
        // IB beats JUMP; ack after 2 cycles.
        run_event(1, 0, 1, 0, 0, 0, 32'h0000_4000, 32'h0000_5000, 32'h0, 2, 0);
`ifdef MIST32_BRANCH_STAT_EN
        chk("stat_branch_seq", oSTAT_BRANCH, 32'd2);
        chk("stat_miss_seq", oSTAT_MISS, 32'd1);
`endif

        // Async reset while a redirect is pending.
        iJUMP_VALID = 1; iPRED_TAKEN = 0; iBRANCH_ADDR = 32'h0000_8000; iEXE_VALID = 1;
        tick();
        clear_event();
        tick();
        chk("pre_rst_valid", oREDIRECT_VALID, 1);
        inRESET = 0;
        #1;
        chk("midrst_valid", oREDIRECT_VALID, 0);
        chk("midrst_addr", oREDIRECT_ADDR, 0);
        chk("midrst_busy", oEXE_BUSY, 0);
        chk("midrst_flush", oFLUSH, 0);
        exp_branch = 0; exp_miss = 0;
        chk_stats();
        tick();
        inRESET = 1;
        run_event(0, 0, 0, 1, 0, 0, 32'h0000_0200, 32'h0, 32'h0, 1, 0);

        // Synchronous clear while waiting on an IB ack.
        iIB_VALID = 1; iEXE_VALID = 1;
        tick();
        clear_event();
        tick();
        chk("pre_sync_ib", oIB_REQ, 1);
        iRESET_SYNC = 1;
        tick();
        iRESET_SYNC = 0;
        chk("sync_ib", oIB_REQ, 0);
        chk("sync_busy", oEXE_BUSY, 0);
        chk("sync_addr", oREDIRECT_ADDR, 0);
        exp_branch = 0; exp_miss = 0;
        chk_stats();

        // Randomised traffic against the reference model.
        for (int n = 0; n < 150; n++) begin
            bit j, nj, ib, idts, hlt, pt;
            logic [31:0] pc, ba, pa;
            j    = 1'($urandom_range(0, 1));
            nj   = 1'($urandom_range(0, 1));
            ib   = ($urandom_range(0, 5) == 0);
            idts = ($urandom_range(0, 5) == 0);
            hlt  = ($urandom_range(0, 7) == 0);
            pt   = 1'($urandom_range(0, 1));
            pc   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            ba   = $urandom;
            pa   = ($urandom_range(0, 1) == 1) ? ba : $urandom;
            run_event(j, nj, ib, idts, hlt, pt, pc, ba, pa,
                      $urandom_range(0, 3), $urandom_range(0, 4));
            iWAKEUP = 1'($urandom_range(0, 1));
            iIB_ACK = 1'($urandom_range(0, 1));
            iREDIRECT_READY = 1'($urandom_range(0, 1));
            tick();
            iWAKEUP = 0; iIB_ACK = 0; iREDIRECT_READY = 0;
            chk("idle_stray_busy", oEXE_BUSY, 0);
            chk("idle_stray_halt", oHALT, 0);
        end
        chk_stats();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
